cgra_kernel_ctrl: RTL and testbench
===================================

Name: cgra_kernel_ctrl

Overview:
- Parametrised kernel controller for the CGRA tile.
- Generalises the fixed two-data-port load/store interface to NUM_CH independent BRAM channels, each with a per-kernel base address, stride and read/write mode.
- Owns the Computation_Start/Computation_Done software handshake and launches the PE array.
- Adds behaviour the current interface lacks:
  - per-channel streaming address generation,
  - a run-cycle counter,
  - a launch timeout with error flag.

Parameters:
NUM_CH, 4, number of BRAM data channels
SYS_DWIDTH, 32, width of Cycle_Count
AWIDTH, 16, BRAM address width per channel
BYTE_LEN, 4, write-enable bits per channel
TIMEOUT, 1024, max cycles to wait for PE_Array_Busy to rise after launch

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
Computation_Start  in  1  software start level
Computation_Done  out  1  kernel done level
Error  out  1  launch timeout occurred (sticky until next start)
Cfg_Base  in  NUM_CH*AWIDTH  per-channel start address, channel i at [i*AWIDTH +: AWIDTH]
Cfg_Stride  in  NUM_CH*AWIDTH  per-channel address increment
Cfg_Wr_Mask  in  NUM_CH  1 = channel i stores, 0 = loads
PE_Array_Go  out  1  one-cycle launch pulse to PE array
PE_Array_Busy  in  1  PE array executing
Bram_En  out  NUM_CH  per-channel enable
Bram_Wen  out  NUM_CH*BYTE_LEN  per-channel byte write enables
Bram_Addr  out  NUM_CH*AWIDTH  per-channel address
Cycle_Count  out  SYS_DWIDTH  busy cycles of last/current kernel

Behaviour:
- Single clock domain: Clk.
- Reset is synchronous and active-high on Rst, sampled on rising Clk.
- All outputs are registered.
- Reset values:
  - State = IDLE.
  - Computation_Done, Error, PE_Array_Go = 0.
  - Bram_En, Bram_Wen, Bram_Addr = 0.
  - Cycle_Count = 0.
- State machine:
  - IDLE:
    - On Computation_Start=1: latch Cfg_Base, Cfg_Stride, Cfg_Wr_Mask into shadow registers; clear Error and Cycle_Count; load address counters with base. Next state ARM.
    - Config inputs are ignored outside this transition.
  - ARM: PE_Array_Go=1 for exactly this cycle; clear timeout counter. Next state WAIT.
  - WAIT:
    - If PE_Array_Busy=1, go to RUN.
    - Else increment the timeout counter. When it reaches TIMEOUT, set Error=1 and go to DONE.
    - With Busy high on the first WAIT cycle, RUN is entered 2 cycles after ARM.
  - RUN, for each cycle with PE_Array_Busy=1 sampled:
    - Next cycle, Bram_En[i]=1 for all channels.
    - Bram_Addr[i] = current counter value.
    - Bram_Wen[i] = all ones if Cfg_Wr_Mask[i], else 0.
    - Counter[i] += stride[i], modulo 2^AWIDTH (wraps silently).
    - Cycle_Count += 1, saturating at all ones.
    - When Busy is sampled 0: next cycle Bram_En and Bram_Wen = 0, Bram_Addr holds its last value; go to DONE.
  - DONE:
    - Computation_Done=1.
    - Remain while Computation_Start=1; go to IDLE when Computation_Start=0.
    - Done is asserted at least 1 cycle: exactly 1 cycle if Start is already low on entry.
    - Computation_Done deasserts the cycle after Start is sampled low.
- First access uses address = base; the k-th busy cycle uses base + (k-1)*stride.
- Computation_Start deasserted during ARM/WAIT/RUN: ignored; the kernel completes normally.
- Busy dropping then rising again in DONE/IDLE: ignored; no BRAM activity outside RUN.
- Rst asserted mid-operation: next cycle all outputs return to reset values and state = IDLE. No Done pulse is produced.
- Stride 0 is legal: the address stays at base.
- Cycle_Count and Error hold their values in IDLE until the next start.

Test Plan:
- Reset, then Start=1 with NUM_CH=4, bases 0x10/0x20/0x30/0x40, stride 4, mask 0b0101; Busy high 3 cycles -> PE_Array_Go pulses once; ch0 addresses 0x10,0x14,0x18 with Wen=0xF; ch1 addresses 0x20,0x24,0x28 with Wen=0; Cycle_Count=3; Done=1 until Start drops.
- Base 0xFFFC, stride 4, Busy 3 cycles -> addresses 0xFFFC, 0x0000, 0x0004 (wrap).
- Start=1, Busy never rises -> Error=1 and Done=1 exactly TIMEOUT+1 cycles after ARM; Bram_En never asserted.
- Start pulsed low after one cycle, Busy high 5 cycles -> run completes; Done high exactly 1 cycle; Cycle_Count=5.
- Rst asserted on 2nd RUN cycle -> next cycle all outputs 0, state IDLE; Done never asserted.
- Cfg_Base changed during RUN -> addresses unaffected; new base used only after the next start.

Source files
------------

// File: rtl/cgra_kernel_ctrl_if.sv
// rtl/cgra_kernel_ctrl_if.sv - host/PE/BRAM signal bundle for the CGRA kernel controller
interface cgra_kernel_ctrl_if #(
  parameter int NUM_CH     = 4,
  parameter int SYS_DWIDTH = 32,
  parameter int AWIDTH     = 16,
  parameter int BYTE_LEN   = 4
);
  logic                       Computation_Start;
  logic                       Computation_Done;
  logic                       Error;
  logic [NUM_CH*AWIDTH-1:0]   Cfg_Base;
  logic [NUM_CH*AWIDTH-1:0]   Cfg_Stride;
  logic [NUM_CH-1:0]          Cfg_Wr_Mask;
  logic                       PE_Array_Go;
  logic                       PE_Array_Busy;
  logic [NUM_CH-1:0]          Bram_En;
  logic [NUM_CH*BYTE_LEN-1:0] Bram_Wen;
  logic [NUM_CH*AWIDTH-1:0]   Bram_Addr;
  logic [SYS_DWIDTH-1:0]      Cycle_Count;

  modport master (
    output Computation_Start, Cfg_Base, Cfg_Stride, Cfg_Wr_Mask, PE_Array_Busy,
    input  Computation_Done, Error, PE_Array_Go, Bram_En, Bram_Wen, Bram_Addr, Cycle_Count
  );

  modport slave (
    input  Computation_Start, Cfg_Base, Cfg_Stride, Cfg_Wr_Mask, PE_Array_Busy,
    output Computation_Done, Error, PE_Array_Go, Bram_En, Bram_Wen, Bram_Addr, Cycle_Count
  );
endinterface

// File: rtl/cgra_kernel_ctrl.sv
// rtl/cgra_kernel_ctrl.sv - kernel launch FSM with per-channel strided BRAM address generation
module cgra_kernel_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int SYS_DWIDTH = 32,
  parameter int AWIDTH     = 16,
  parameter int BYTE_LEN   = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic               Clk,
  input logic               Rst,
  cgra_kernel_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_RUN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       go_q, go_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic [NUM_CH-1:0]          mask_q, mask_d;
  logic [NUM_CH*BYTE_LEN-1:0] wen_q, wen_d;
  logic [NUM_CH*AWIDTH-1:0]   addr_q, addr_d;
  logic [NUM_CH*AWIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_CH*AWIDTH-1:0]   stride_q, stride_d;
  logic [SYS_DWIDTH-1:0]      cyc_q, cyc_d;
  logic [TW-1:0]              tmo_q, tmo_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
      en_q     <= '0;
      mask_q   <= '0;
      wen_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      stride_q <= '0;
      cyc_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      go_q     <= go_d;
      en_q     <= en_d;
      mask_q   <= mask_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      stride_q <= stride_d;
      cyc_q    <= cyc_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    go_d     = 1'b0;
    en_d     = en_q;
    mask_d   = mask_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    stride_d = stride_q;
    cyc_d    = cyc_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        // Base goes straight into the address counters; only stride and mask need shadowing.
        if (bus.Computation_Start) begin
          stride_d = bus.Cfg_Stride;
          mask_d   = bus.Cfg_Wr_Mask;
          cnt_d    = bus.Cfg_Base;
          err_d    = 1'b0;
          cyc_d    = '0;
          go_d     = 1'b1;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.PE_Array_Busy) begin
          state_d = S_RUN;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (bus.PE_Array_Busy) begin
          en_d   = '1;
          addr_d = cnt_q;
          for (int i = 0; i < NUM_CH; i++) begin
            wen_d[i*BYTE_LEN +: BYTE_LEN] = {BYTE_LEN{mask_q[i]}};
            cnt_d[i*AWIDTH +: AWIDTH]     = cnt_q[i*AWIDTH +: AWIDTH] + stride_q[i*AWIDTH +: AWIDTH];
          end
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        end else begin
          en_d    = '0;
          wen_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.Computation_Start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Computation_Done = done_q;
  assign bus.Error            = err_q;
  assign bus.PE_Array_Go      = go_q;
  assign bus.Bram_En          = en_q;
  assign bus.Bram_Wen         = wen_q;
  assign bus.Bram_Addr        = addr_q;
  assign bus.Cycle_Count      = cyc_q;
endmodule

// File: tb/tb_cgra_kernel_ctrl.sv
// tb/tb_cgra_kernel_ctrl.sv - scoreboard bench for cgra_kernel_ctrl
module tb_cgra_kernel_ctrl;
  localparam int TIMEOUT = 1024;

  typedef struct packed {
    logic [3:0]  en;
    logic [15:0] wen;
    logic [63:0] addr;
  } acc_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  acc_t sb[$];

  cgra_kernel_ctrl_if #(.NUM_CH(4), .SYS_DWIDTH(32), .AWIDTH(16), .BYTE_LEN(4)) bus ();

  cgra_kernel_ctrl #(
    .NUM_CH(4), .SYS_DWIDTH(32), .AWIDTH(16), .BYTE_LEN(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Every BRAM access the DUT makes must match the oldest expected access.
  always @(negedge Clk) begin
    acc_t e;
    if (bus.Bram_En !== 4'h0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL bram_unexpected: got en=%h addr=%h, required no access", bus.Bram_En, bus.Bram_Addr);
      end else begin
        e = sb.pop_front();
        if ({bus.Bram_En, bus.Bram_Wen, bus.Bram_Addr} !== e) begin
          n_err++;
          $display("FAIL bram_access: got en=%h wen=%h addr=%h, required en=%h wen=%h addr=%h",
                   bus.Bram_En, bus.Bram_Wen, bus.Bram_Addr, e.en, e.wen, e.addr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_run(input logic [63:0] base, input logic [63:0] stride, input logic [63:0] mid_base,
                           input logic [3:0] mask, input int nbusy, input bit drop_start,
                           output int go_cnt, output logic [63:0] last_addr);
    acc_t e;
    bus.Cfg_Base          = base;
    bus.Cfg_Stride        = stride;
    bus.Cfg_Wr_Mask       = mask;
    bus.Computation_Start = 1'b1;
    bus.PE_Array_Busy     = 1'b1;
    go_cnt    = 0;
    last_addr = '0;
    tick();
    if (bus.PE_Array_Go === 1'b1) go_cnt++;
    if (drop_start) bus.Computation_Start = 1'b0;
    tick();
    if (bus.PE_Array_Go === 1'b1) go_cnt++;
    tick();
    if (bus.PE_Array_Go === 1'b1) go_cnt++;
    bus.Cfg_Base = mid_base;
    for (int k = 0; k < nbusy; k++) begin
      e.en = 4'hF;
      for (int ch = 0; ch < 4; ch++) begin
        e.addr[ch*16 +: 16] = base[ch*16 +: 16] + 16'(k) * stride[ch*16 +: 16];
        e.wen[ch*4 +: 4]    = {4{mask[ch]}};
      end
      sb.push_back(e);
      last_addr = e.addr;
      tick();
      if (bus.PE_Array_Go === 1'b1) go_cnt++;
    end
    bus.PE_Array_Busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    n_cmp++; if (bus.Computation_Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", bus.Computation_Done); end
    n_cmp++; if (bus.Error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b required 0", bus.Error); end
    n_cmp++; if (bus.PE_Array_Go !== 1'b0) begin n_err++; $display("FAIL reset_go: got %b required 0", bus.PE_Array_Go); end
    n_cmp++; if (bus.Bram_En !== 4'h0) begin n_err++; $display("FAIL reset_en: got %h required 0", bus.Bram_En); end
    n_cmp++; if (bus.Bram_Wen !== 16'h0) begin n_err++; $display("FAIL reset_wen: got %h required 0", bus.Bram_Wen); end
    n_cmp++; if (bus.Bram_Addr !== 64'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", bus.Bram_Addr); end
    n_cmp++; if (bus.Cycle_Count !== 32'h0) begin n_err++; $display("FAIL reset_cycles: got %0d required 0", bus.Cycle_Count); end
    tick();
    n_cmp++; if (bus.PE_Array_Go !== 1'b0) begin n_err++; $display("FAIL idle_no_go: got %b required 0", bus.PE_Array_Go); end
  endtask

  task automatic test_basic();
    int go_cnt;
    logic [63:0] last;
    drive_run({16'h40, 16'h30, 16'h20, 16'h10}, {4{16'h4}}, {16'h40, 16'h30, 16'h20, 16'h10},
              4'b0101, 3, 1'b0, go_cnt, last);
    n_cmp++; if (go_cnt != 1) begin n_err++; $display("FAIL basic_go_pulses: got %0d required 1", go_cnt); end
    n_cmp++; if (bus.Computation_Done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b required 1", bus.Computation_Done); end
    n_cmp++; if (bus.Error !== 1'b0) begin n_err++; $display("FAIL basic_error: got %b required 0", bus.Error); end
    n_cmp++; if (bus.Bram_En !== 4'h0 || bus.Bram_Wen !== 16'h0) begin n_err++; $display("FAIL basic_en_off: got en=%h wen=%h required 0", bus.Bram_En, bus.Bram_Wen); end
    n_cmp++; if (bus.Bram_Addr !== last) begin n_err++; $display("FAIL basic_addr_hold: got %h required %h", bus.Bram_Addr, last); end
    n_cmp++; if (bus.Bram_Addr[31:0] !== 32'h0028_0018) begin n_err++; $display("FAIL basic_last_ch01: got %h required 00280018", bus.Bram_Addr[31:0]); end
    n_cmp++; if (bus.Cycle_Count !== 32'd3) begin n_err++; $display("FAIL basic_cycles: got %0d required 3", bus.Cycle_Count); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_sb_drain: got %0d pending required 0", sb.size()); end
    tick();
    n_cmp++; if (bus.Computation_Done !== 1'b1) begin n_err++; $display("FAIL basic_done_hold: got %b required 1", bus.Computation_Done); end
    bus.Computation_Start = 1'b0;
    tick();
    n_cmp++; if (bus.Computation_Done !== 1'b0) begin n_err++; $display("FAIL basic_done_clear: got %b required 0", bus.Computation_Done); end
    n_cmp++; if (bus.Cycle_Count !== 32'd3) begin n_err++; $display("FAIL basic_cycles_idle: got %0d required 3", bus.Cycle_Count); end
  endtask

  task automatic test_wrap();
    int go_cnt;
    logic [63:0] last;
    drive_run({16'h0100, 16'h0200, 16'h0300, 16'hFFFC}, {16'h1, 16'h2, 16'h3, 16'h4},
              {16'h0100, 16'h0200, 16'h0300, 16'hFFFC}, 4'b1111, 3, 1'b0, go_cnt, last);
    n_cmp++; if (bus.Bram_Addr[15:0] !== 16'h0004) begin n_err++; $display("FAIL wrap_last_ch0: got %h required 0004", bus.Bram_Addr[15:0]); end
    n_cmp++; if (bus.Cycle_Count !== 32'd3) begin n_err++; $display("FAIL wrap_cycles: got %0d required 3", bus.Cycle_Count); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL wrap_sb_drain: got %0d pending required 0", sb.size()); end
    bus.Computation_Start = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int c = 0;
    int done_at = -1;
    bit seen_en = 1'b0;
    bus.Cfg_Base = {4{16'h0ABC}};
    bus.Cfg_Stride = {4{16'h1}};
    bus.Cfg_Wr_Mask = 4'hF;
    bus.Computation_Start = 1'b1;
    bus.PE_Array_Busy = 1'b0;
    tick();
    n_cmp++; if (bus.PE_Array_Go !== 1'b1) begin n_err++; $display("FAIL timeout_go: got %b required 1", bus.PE_Array_Go); end
    for (int i = 0; i < TIMEOUT + 20 && done_at < 0; i++) begin
      tick();
      c++;
      if (bus.Bram_En !== 4'h0) seen_en = 1'b1;
      if (bus.Computation_Done === 1'b1) done_at = c;
    end
    n_cmp++; if (done_at != TIMEOUT + 1) begin n_err++; $display("FAIL timeout_latency: got %0d required %0d", done_at, TIMEOUT + 1); end
    n_cmp++; if (bus.Error !== 1'b1) begin n_err++; $display("FAIL timeout_error: got %b required 1", bus.Error); end
    n_cmp++; if (seen_en) begin n_err++; $display("FAIL timeout_no_bram: got en seen required none"); end
    bus.Computation_Start = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.Computation_Done !== 1'b0) begin n_err++; $display("FAIL timeout_done_clear: got %b required 0", bus.Computation_Done); end
    n_cmp++; if (bus.Error !== 1'b1) begin n_err++; $display("FAIL timeout_error_sticky: got %b required 1", bus.Error); end
  endtask

  task automatic test_rst_mid();
    acc_t e;
    int go_cnt;
    bit done_seen = 1'b0;
    logic [63:0] last;
    bus.Cfg_Base = {16'h0800, 16'h0700, 16'h0600, 16'h0500};
    bus.Cfg_Stride = {4{16'h2}};
    bus.Cfg_Wr_Mask = 4'b0011;
    bus.Computation_Start = 1'b1;
    bus.PE_Array_Busy = 1'b1;
    tick();
    n_cmp++; if (bus.Error !== 1'b0) begin n_err++; $display("FAIL start_clears_error: got %b required 0", bus.Error); end
    n_cmp++; if (bus.Cycle_Count !== 32'd0) begin n_err++; $display("FAIL start_clears_cycles: got %0d required 0", bus.Cycle_Count); end
    tick();
    tick();
    e.en = 4'hF;
    e.wen = 16'h00FF;
    e.addr = {16'h0800, 16'h0700, 16'h0600, 16'h0500};
    sb.push_back(e);
    tick();
    n_cmp++; if (bus.Cycle_Count !== 32'd1) begin n_err++; $display("FAIL rst_mid_cycles: got %0d required 1", bus.Cycle_Count); end
    Rst = 1'b1;
    tick();
    n_cmp++; if ({bus.Computation_Done, bus.Error, bus.PE_Array_Go} !== 3'b000) begin n_err++; $display("FAIL rst_mid_flags: got %b required 000", {bus.Computation_Done, bus.Error, bus.PE_Array_Go}); end
    n_cmp++; if (bus.Bram_En !== 4'h0 || bus.Bram_Wen !== 16'h0 || bus.Bram_Addr !== 64'h0) begin n_err++; $display("FAIL rst_mid_bram: got en=%h wen=%h addr=%h required 0", bus.Bram_En, bus.Bram_Wen, bus.Bram_Addr); end
    n_cmp++; if (bus.Cycle_Count !== 32'd0) begin n_err++; $display("FAIL rst_mid_cycles_clear: got %0d required 0", bus.Cycle_Count); end
    Rst = 1'b0;
    bus.Computation_Start = 1'b0;
    bus.PE_Array_Busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Computation_Done !== 1'b0) done_seen = 1'b1;
    end
    n_cmp++; if (done_seen) begin n_err++; $display("FAIL rst_mid_no_done: got done asserted required none"); end
    drive_run({4{16'h0001}}, {4{16'h1}}, {4{16'h0001}}, 4'b0000, 1, 1'b0, go_cnt, last);
    n_cmp++; if (go_cnt != 1) begin n_err++; $display("FAIL rst_mid_relaunch_go: got %0d required 1", go_cnt); end
    n_cmp++; if (bus.Cycle_Count !== 32'd1) begin n_err++; $display("FAIL rst_mid_relaunch_cycles: got %0d required 1", bus.Cycle_Count); end
    bus.Computation_Start = 1'b0;
    tick();
  endtask

  task automatic test_start_pulse();
    int go_cnt;
    bit en_seen = 1'b0;
    logic [63:0] last;
    drive_run({16'h4000, 16'h3000, 16'h2000, 16'h1000}, {16'h4, 16'h3, 16'h2, 16'h1},
              {16'h4000, 16'h3000, 16'h2000, 16'h1000}, 4'b1010, 5, 1'b1, go_cnt, last);
    n_cmp++; if (go_cnt != 1) begin n_err++; $display("FAIL pulse_go: got %0d required 1", go_cnt); end
    n_cmp++; if (bus.Computation_Done !== 1'b1) begin n_err++; $display("FAIL pulse_done: got %b required 1", bus.Computation_Done); end
    n_cmp++; if (bus.Cycle_Count !== 32'd5) begin n_err++; $display("FAIL pulse_cycles: got %0d required 5", bus.Cycle_Count); end
    tick();
    n_cmp++; if (bus.Computation_Done !== 1'b0) begin n_err++; $display("FAIL pulse_done_one_cycle: got %b required 0", bus.Computation_Done); end
    bus.PE_Array_Busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.Bram_En !== 4'h0 || bus.PE_Array_Go !== 1'b0) en_seen = 1'b1;
    end
    bus.PE_Array_Busy = 1'b0;
    tick();
    n_cmp++; if (en_seen) begin n_err++; $display("FAIL idle_busy_ignored: got activity required none"); end
  endtask

  task automatic test_back_to_back();
    int go_cnt;
    logic [63:0] last;
    drive_run({16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00}, {4{16'h10}},
              {16'h7700, 16'h6600, 16'h5500, 16'h4400}, 4'b1100, 4, 1'b0, go_cnt, last);
    n_cmp++; if (bus.Bram_Addr !== last) begin n_err++; $display("FAIL cfg_change_addr: got %h required %h", bus.Bram_Addr, last); end
    bus.Computation_Start = 1'b0;
    tick();
    drive_run({16'h7700, 16'h6600, 16'h5500, 16'h4400}, {16'h8, 16'h0, 16'h8, 16'h8},
              {16'h7700, 16'h6600, 16'h5500, 16'h4400}, 4'b0110, 3, 1'b0, go_cnt, last);
    n_cmp++; if (bus.Bram_Addr[47:32] !== 16'h6600) begin n_err++; $display("FAIL stride0_ch2: got %h required 6600", bus.Bram_Addr[47:32]); end
    n_cmp++; if (bus.Bram_Addr[15:0] !== 16'h4410) begin n_err++; $display("FAIL new_base_ch0: got %h required 4410", bus.Bram_Addr[15:0]); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_sb_drain: got %0d pending required 0", sb.size()); end
    bus.Computation_Start = 1'b0;
    tick();
  endtask

  initial begin
    bus.Computation_Start = 1'b0;
    bus.Cfg_Base = '0;
    bus.Cfg_Stride = '0;
    bus.Cfg_Wr_Mask = '0;
    bus.PE_Array_Busy = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_rst_mid();
    test_start_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
